// File: rtl/mc_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
//   op, funct   : opcode and function fields from the instruction register
//   zero        : ALU zero flag
//   pcen .. alucontrol : per-cycle write enables and mux selects
//   state       : controller state, exported for debug/verification
// The master modport is the controller side; the slave modport is the datapath side.
interface mc_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    modport master (
        input  op, funct, zero,
        output pcen, memwrite, irwrite, regwrite, iord, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, alucontrol, state
    );

    modport slave (
        output op, funct, zero,
        input  pcen, memwrite, irwrite, regwrite, iord, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, alucontrol, state
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM plus ALU decoder.
// Supports lw, sw, R-type (add, sub, and, or, slt), beq, addi and j;
// an instruction takes 3-5 cycles, an unsupported opcode is a 2-cycle no-op.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-high; loads FETCH and blocks all writes while high
//   bus   : mc_if.master -- op/funct/zero in, enables/selects/state out
module mc_controller (
    input  logic clk,
    input  logic reset,
    mc_if.master bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Plain vector rather than state_t so the unused codes 12-15 are representable
    // and recover through the default branch of the next-state logic.
    logic [3:0] state_r;
    state_t     next_state;

    logic [3:0] dec_state;
    logic       pcwrite;
    logic       branch;
    logic       memwrite_raw;
    logic       irwrite_raw;
    logic       regwrite_raw;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic [2:0] alucontrol;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values.
        if (reset)
            state_r <= FETCH;
        else
            state_r <= next_state;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = FETCH;
        case (state_r)
            FETCH:  next_state = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECUTE;
                    OP_BEQ:       next_state = BRANCH;
                    OP_ADDI:      next_state = ADDIEXEC;
                    OP_J:         next_state = JUMP;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR:   next_state = (bus.op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:    next_state = MEMWB;
            EXECUTE:  next_state = ALUWB;
            ADDIEXEC: next_state = ADDIWB;
            default:  next_state = FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore outputs. During reset the selects show FETCH values and the
    // write enables are masked below, so an aborted instruction writes nothing.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        pcwrite      = 1'b0;
        branch       = 1'b0;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        iord         = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        aluop        = 2'b00;

        dec_state = reset ? FETCH : state_r;
        case (dec_state)
            FETCH: begin
                irwrite_raw = 1'b1;
                pcwrite     = 1'b1;
                alusrcb     = 2'b01;
            end
            DECODE:   alusrcb = 2'b11;          // branch target precompute
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD:    iord = 1'b1;
            MEMWB: begin
                regwrite_raw = 1'b1;
                memtoreg     = 1'b1;
            end
            MEMWR: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            ALUWB: begin
                regwrite_raw = 1'b1;
                regdst       = 1'b1;
            end
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB:   regwrite_raw = 1'b1;
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU decoder
    // ------------------------------------------------------------------
    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            2'b01: alucontrol = 3'b110;
            2'b10: begin
                case (bus.funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign bus.pcen       = ~reset & (pcwrite | (branch & bus.zero));
    assign bus.memwrite   = ~reset & memwrite_raw;
    assign bus.irwrite    = ~reset & irwrite_raw;
    assign bus.regwrite   = ~reset & regwrite_raw;
    assign bus.iord       = iord;
    assign bus.regdst     = regdst;
    assign bus.memtoreg   = memtoreg;
    assign bus.alusrca    = alusrca;
    assign bus.alusrcb    = alusrcb;
    assign bus.pcsrc      = pcsrc;
    assign bus.alucontrol = alucontrol;
    assign bus.state      = state_r;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller. Each cycle the full output bundle
// {state, pcen, memwrite, irwrite, regwrite, iord, regdst, memtoreg, alusrca,
//  alusrcb, pcsrc, alucontrol} is compared against hand-written vectors.
module tb_mc_controller;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    mc_if bus ();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed bundle: state(4) en(4: pcen,memwrite,irwrite,regwrite)
    // mux(4: iord,regdst,memtoreg,alusrca) alusrcb(2) pcsrc(2) alucontrol(3)
    logic [18:0] obs;
    assign obs = {bus.state,
                  bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite,
                  bus.iord, bus.regdst, bus.memtoreg, bus.alusrca,
                  bus.alusrcb, bus.pcsrc, bus.alucontrol};

    localparam logic [18:0] V_RST    = {4'd0,  4'b0000, 4'b0000, 2'b01, 2'b00, 3'b010};
    localparam logic [18:0] V_FETCH  = {4'd0,  4'b1010, 4'b0000, 2'b01, 2'b00, 3'b010};
    localparam logic [18:0] V_DECODE = {4'd1,  4'b0000, 4'b0000, 2'b11, 2'b00, 3'b010};
    localparam logic [18:0] V_MEMADR = {4'd2,  4'b0000, 4'b0001, 2'b10, 2'b00, 3'b010};
    localparam logic [18:0] V_MEMRD  = {4'd3,  4'b0000, 4'b1000, 2'b00, 2'b00, 3'b010};
    localparam logic [18:0] V_MEMWB  = {4'd4,  4'b0001, 4'b0010, 2'b00, 2'b00, 3'b010};
    localparam logic [18:0] V_MEMWR  = {4'd5,  4'b0100, 4'b1000, 2'b00, 2'b00, 3'b010};
    localparam logic [18:0] V_ALUWB  = {4'd7,  4'b0001, 4'b0100, 2'b00, 2'b00, 3'b010};
    localparam logic [18:0] V_BRN_Z0 = {4'd8,  4'b0000, 4'b0001, 2'b00, 2'b01, 3'b110};
    localparam logic [18:0] V_BRN_Z1 = {4'd8,  4'b1000, 4'b0001, 2'b00, 2'b01, 3'b110};
    localparam logic [18:0] V_ADDIEX = {4'd9,  4'b0000, 4'b0001, 2'b10, 2'b00, 3'b010};
    localparam logic [18:0] V_ADDIWB = {4'd10, 4'b0001, 4'b0000, 2'b00, 2'b00, 3'b010};
    localparam logic [18:0] V_JUMP   = {4'd11, 4'b1000, 4'b0000, 2'b00, 2'b10, 3'b010};
    localparam logic [18:0] V_RST_RD = {4'd3,  4'b0000, 4'b0000, 2'b01, 2'b00, 3'b010};
    localparam logic [18:0] V_ILL13  = {4'd13, 4'b0000, 4'b0000, 2'b00, 2'b00, 3'b010};

    // Advance one clock and settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.op    = 6'b111111;
        bus.funct = 6'b000000;
        bus.zero  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if (obs !== V_RST) begin
                $display("FAIL reset_hold cyc%0d: got %h want %h", i, obs, V_RST);
                n_err++;
            end
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if (obs !== V_FETCH) begin
            $display("FAIL reset_release: got %h want %h", obs, V_FETCH);
            n_err++;
        end
    endtask

    task automatic test_lw();
        logic [18:0] exp_seq [6];
        exp_seq = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMRD, V_MEMWB, V_FETCH};
        bus.op = 6'b100011;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            n_vec++;
            if (obs !== exp_seq[i]) begin
                $display("FAIL lw step%0d: got %h want %h", i, obs, exp_seq[i]);
                n_err++;
            end
        end
    endtask

    task automatic test_sw();
        logic [18:0] exp_seq [5];
        exp_seq = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWR, V_FETCH};
        bus.op = 6'b101011;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            n_vec++;
            if (obs !== exp_seq[i]) begin
                $display("FAIL sw step%0d: got %h want %h", i, obs, exp_seq[i]);
                n_err++;
            end
        end
    endtask

    task automatic test_rtype();
        logic [5:0]  functs  [6];
        logic [2:0]  ctl     [6];
        logic [18:0] exp_seq [5];
        functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
        ctl    = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111,    3'b010};
        bus.op = 6'b000000;
        for (int k = 0; k < 6; k++) begin
            bus.funct  = functs[k];
            exp_seq[0] = V_FETCH;
            exp_seq[1] = V_DECODE;
            exp_seq[2] = {4'd6, 4'b0000, 4'b0001, 2'b00, 2'b00, ctl[k]};
            exp_seq[3] = V_ALUWB;
            exp_seq[4] = V_FETCH;
            for (int i = 0; i < 5; i++) begin
                if (i > 0) tick();
                n_vec++;
                if (obs !== exp_seq[i]) begin
                    $display("FAIL rtype funct=%b step%0d: got %h want %h",
                             functs[k], i, obs, exp_seq[i]);
                    n_err++;
                end
            end
        end
        bus.funct = 6'b000000;
    endtask

    task automatic test_beq();
        logic [18:0] exp_seq [4];
        bus.op = 6'b000100;
        for (int z = 0; z < 2; z++) begin
            bus.zero   = (z == 1);
            exp_seq[0] = V_FETCH;
            exp_seq[1] = V_DECODE;
            exp_seq[2] = (z == 1) ? V_BRN_Z1 : V_BRN_Z0;
            exp_seq[3] = V_FETCH;
            for (int i = 0; i < 4; i++) begin
                if (i > 0) tick();
                n_vec++;
                if (obs !== exp_seq[i]) begin
                    $display("FAIL beq zero=%0d step%0d: got %h want %h", z, i, obs, exp_seq[i]);
                    n_err++;
                end
            end
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_addi();
        logic [18:0] exp_seq [5];
        exp_seq = '{V_FETCH, V_DECODE, V_ADDIEX, V_ADDIWB, V_FETCH};
        bus.op = 6'b001000;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            n_vec++;
            if (obs !== exp_seq[i]) begin
                $display("FAIL addi step%0d: got %h want %h", i, obs, exp_seq[i]);
                n_err++;
            end
        end
    endtask

    task automatic test_jump();
        logic [18:0] exp_seq [4];
        exp_seq = '{V_FETCH, V_DECODE, V_JUMP, V_FETCH};
        bus.op = 6'b000010;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            n_vec++;
            if (obs !== exp_seq[i]) begin
                $display("FAIL j step%0d: got %h want %h", i, obs, exp_seq[i]);
                n_err++;
            end
        end
    endtask

    task automatic test_unsupported();
        logic [18:0] exp_seq [3];
        exp_seq = '{V_FETCH, V_DECODE, V_FETCH};
        bus.op = 6'b111111;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            n_vec++;
            if (obs !== exp_seq[i]) begin
                $display("FAIL unsupported step%0d: got %h want %h", i, obs, exp_seq[i]);
                n_err++;
            end
        end
    endtask

    task automatic test_reset_mid_lw();
        logic [18:0] exp_seq [4];
        exp_seq = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMRD};
        bus.op = 6'b100011;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            n_vec++;
            if (obs !== exp_seq[i]) begin
                $display("FAIL lw_abort step%0d: got %h want %h", i, obs, exp_seq[i]);
                n_err++;
            end
        end
        // Now in MEMRD: assert reset, writes must drop immediately.
        reset = 1'b1;
        #1;
        n_vec++;
        if (obs !== V_RST_RD) begin
            $display("FAIL lw_abort in_memrd: got %h want %h", obs, V_RST_RD);
            n_err++;
        end
        tick();
        n_vec++;
        if (obs !== V_RST) begin
            $display("FAIL lw_abort after_edge: got %h want %h", obs, V_RST);
            n_err++;
        end
        bus.op = 6'b111111;
        reset  = 1'b0;
        #1;
        n_vec++;
        if (obs !== V_FETCH) begin
            $display("FAIL lw_abort release: got %h want %h", obs, V_FETCH);
            n_err++;
        end
        tick();
        n_vec++;
        if (obs !== V_DECODE) begin
            $display("FAIL lw_abort resume: got %h want %h", obs, V_DECODE);
            n_err++;
        end
        tick();
        n_vec++;
        if (obs !== V_FETCH) begin
            $display("FAIL lw_abort noop_end: got %h want %h", obs, V_FETCH);
            n_err++;
        end
    endtask

    task automatic test_illegal_state();
        // Walk a jump to JUMP (whose successor is FETCH anyway), then
        // overwrite the state register with illegal code 13.
        bus.op = 6'b000010;
        tick();
        tick();
        n_vec++;
        if (obs !== V_JUMP) begin
            $display("FAIL illegal setup: got %h want %h", obs, V_JUMP);
            n_err++;
        end
        force dut.state_r = 4'd13;
        #1;
        n_vec++;
        if (obs !== V_ILL13) begin
            $display("FAIL illegal outputs: got %h want %h", obs, V_ILL13);
            n_err++;
        end
        n_vec++;
        if (dut.next_state !== 4'd0) begin
            $display("FAIL illegal next_state: got %0d want 0", dut.next_state);
            n_err++;
        end
        release dut.state_r;
        tick();
        n_vec++;
        if (obs !== V_FETCH) begin
            $display("FAIL illegal recover: got %h want %h", obs, V_FETCH);
            n_err++;
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b1;
        bus.op    = 6'b000000;
        bus.funct = 6'b000000;
        bus.zero  = 1'b0;

        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_beq();
        test_addi();
        test_jump();
        test_unsupported();
        test_reset_mid_lw();
        test_illegal_state();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
